datapath: RTL and testbench
===========================

# datapath

32-bit single-bus datapath for the simple CPU: a shared bus fed by one-hot `*out` strobes, registers loaded by `*in` strobes on the clock edge, and an ALU stage (Y operand latch, 64-bit Z result). The control unit, or a bench FSM, drives it one control step per clock. Memory is modelled by the `Mdatain` input feeding MDR.

## Interface
- `RESET_PC`, default 32'h0: PC value after reset.
- `Clock` in 1: single clock, rising edge.
- `Clear` in 1: asynchronous, active-low reset.
- `PCout`, `Zlowout`, `MDRout`, `R3out`, `R7out` in 1 each: bus source selects.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin` in 1 each: register load enables.
- `IncPC` in 1: ALU op, result = bus + 1.
- `Read` in 1: MDR input mux selects `Mdatain` instead of the bus.
- `AND` in 1: ALU op, result = Y & bus.
- `R3in`, `R4in`, `R7in` in 1 each: general register load enables.
- `Mdatain` in 32: memory read data.
- `BusMuxOut` out 32: current bus value.
- `Address` out 32: MAR contents.

## Operation
- Registers (all 32-bit): PC, IR, MAR, MDR, Y, R3, R4, R7. Z is 64-bit, split into ZHigh and ZLow.
- Bus is combinational.
  - Source priority: MDRout > Zlowout > PCout > R3out > R7out.
  - No source asserted: bus = 0.
- MDR input = `Read` ? `Mdatain` : bus. MDR loads on `MDRin`.
- Each other register loads the bus when its `*in` is high at the rising edge.
- Simultaneous load of several registers from one bus value is legal.
- ALU result C (64-bit), combinational:
  - `AND` high: C = {32'h0, Y & bus}.
  - Else `IncPC` high: C = {32'h0, bus + 1}. The add wraps modulo 2^32 (0xFFFFFFFF+1 gives 0).
  - Neither high: C = 0.
  - Z loads C on `Zin`.
- Register read-and-write in the same cycle, e.g. `Zlowout` with `Zin`, or `PCout` with `PCin`: the bus carries the old value and the register captures the new one at the edge.
- IR only latches; no decode in this block.

## Timing
- Reset (`Clear` = 0, asynchronous):
  - PC = `RESET_PC`.
  - All other registers and Z = 0.
  - Hence `BusMuxOut` = 0 and `Address` = 0.
  - Reset mid-sequence overrides any pending load.
- Load latency: one edge. A value driven during cycle n is visible in the register after edge n.
- Bus and ALU paths are zero-latency combinational.
- Strobes may change anywhere within the cycle. They must be stable for setup before the rising edge; there is no handshake.
- Instruction fetch sequence, per edge:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin` → MAR = PC, Z = PC + 1.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin` → PC = PC + 1, MDR = `Mdatain`.
  - T2: `MDRout`, `IRin` → IR = MDR.
- AND execute sequence:
  - T3: `R3out`, `Yin` → Y = R3.
  - T4: `R7out`, `AND`, `Zin` → Z = Y & R7.
  - T5: `Zlowout`, `R4in` → R4 = ZLow.

## Configuration
- `DATAPATH_ONEHOT_CHECK_EN` defined: a simulation-only check issues `$error` at any rising edge where more than one bus source strobe is high. Bus priority is unchanged.
- Undefined: no check logic; identical functional behaviour.

## Structure
- Package `datapath_pkg`:
  - `WORD_W` = 32.
  - `word_t` typedef.
  - Bus-source select enum, which documents the priority order.
- One sub-module, `register32`: 32-bit register with enable and async active-low clear, with a parameterised reset value.
  - Instantiated for PC, IR, MAR, MDR, Y, R3, R4, R7, ZHigh and ZLow.
  - Bus mux and ALU stay inline.

## Test plan
- Reset, then release with all strobes low → `Address` = 0, `BusMuxOut` = 0, PC = 0.
- Register preload:
  - `Mdatain` = 0x22 with `Read`+`MDRin`; next cycle `MDRout`+`R3in` → R3 = 0x22.
  - Repeat with 0x24 → R7; repeat with 0x28 → R4.
- Fetch T0–T2 with `Mdatain` = 0x2A2B8000 → MAR = 0, PC = 1, MDR = 0x2A2B8000, IR = 0x2A2B8000.
- AND T3–T5 → Y = 0x22, ZLow = 0x20, ZHigh = 0, R4 = 0x20 (was 0x28).
- IncPC wrap: load PC = 0xFFFFFFFF through MDR, then run T0–T1 → PC = 0.
- Two bus sources together, `MDRout`+`R3out` with MDR = 0x5, R3 = 0x9 → `BusMuxOut` = 0x5. `$error` fires only with `DATAPATH_ONEHOT_CHECK_EN`.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the single-bus CPU datapath: word width and the bus-source
// select, whose declaration order mirrors the bus priority (highest first).
package datapath_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        SRC_MDR,
        SRC_ZLOW,
        SRC_PC,
        SRC_R3,
        SRC_R7,
        SRC_NONE
    } bus_src_e;

endpackage : datapath_pkg

// File: rtl/register32.sv
// 32-bit register with load enable and asynchronous active-low clear to a
// parameterised reset value.
module register32
    import datapath_pkg::*;
#(
    parameter word_t RESET_VAL = '0
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_en,
    input  word_t i_d,
    output word_t o_q
);

    word_t r_q;

    // NOTE: the clear sits in the sensitivity list so it acts without a clock;
    // state is written with <= so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : register32

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: priority bus mux, register file slice, Y/Z ALU.
// Optional macro DATAPATH_ONEHOT_CHECK_EN adds a simulation check for multiple bus drivers.
module datapath
    import datapath_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0
) (
    input  logic  Clock,
    input  logic  Clear,
    input  logic  PCout,
    input  logic  Zlowout,
    input  logic  MDRout,
    input  logic  R3out,
    input  logic  R7out,
    input  logic  MARin,
    input  logic  Zin,
    input  logic  PCin,
    input  logic  MDRin,
    input  logic  IRin,
    input  logic  Yin,
    input  logic  IncPC,
    input  logic  Read,
    input  logic  AND,
    input  logic  R3in,
    input  logic  R4in,
    input  logic  R7in,
    input  word_t Mdatain,
    output word_t BusMuxOut,
    output word_t Address
);

    word_t       w_pc, w_ir, w_mar, w_mdr, w_y, w_r3, w_r4, w_r7, w_zhi, w_zlo;
    word_t       w_bus, w_mdr_d;
    logic [63:0] w_c;
    bus_src_e    w_src;
    logic        w_unused;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_src = SRC_NONE;
        if      (MDRout)  w_src = SRC_MDR;
        else if (Zlowout) w_src = SRC_ZLOW;
        else if (PCout)   w_src = SRC_PC;
        else if (R3out)   w_src = SRC_R3;
        else if (R7out)   w_src = SRC_R7;
    end

    always_comb begin
        w_bus = '0;
        case (w_src)
            SRC_MDR:  w_bus = w_mdr;
            SRC_ZLOW: w_bus = w_zlo;
            SRC_PC:   w_bus = w_pc;
            SRC_R3:   w_bus = w_r3;
            SRC_R7:   w_bus = w_r7;
            default:  w_bus = '0;
        endcase
    end

    always_comb begin
        w_c = '0;
        if (AND)        w_c = {32'h0, w_y & w_bus};
        else if (IncPC) w_c = {32'h0, w_bus + 32'd1};
    end

    assign w_mdr_d = Read ? Mdatain : w_bus;

    register32 #(.RESET_VAL(RESET_PC)) u_pc (.i_clk(Clock), .i_rst_n(Clear), .i_en(PCin),  .i_d(w_bus),       .o_q(w_pc));
    register32 u_ir  (.i_clk(Clock), .i_rst_n(Clear), .i_en(IRin),  .i_d(w_bus),       .o_q(w_ir));
    register32 u_mar (.i_clk(Clock), .i_rst_n(Clear), .i_en(MARin), .i_d(w_bus),       .o_q(w_mar));
    register32 u_mdr (.i_clk(Clock), .i_rst_n(Clear), .i_en(MDRin), .i_d(w_mdr_d),     .o_q(w_mdr));
    register32 u_y   (.i_clk(Clock), .i_rst_n(Clear), .i_en(Yin),   .i_d(w_bus),       .o_q(w_y));
    register32 u_r3  (.i_clk(Clock), .i_rst_n(Clear), .i_en(R3in),  .i_d(w_bus),       .o_q(w_r3));
    register32 u_r4  (.i_clk(Clock), .i_rst_n(Clear), .i_en(R4in),  .i_d(w_bus),       .o_q(w_r4));
    register32 u_r7  (.i_clk(Clock), .i_rst_n(Clear), .i_en(R7in),  .i_d(w_bus),       .o_q(w_r7));
    register32 u_zhi (.i_clk(Clock), .i_rst_n(Clear), .i_en(Zin),   .i_d(w_c[63:32]),  .o_q(w_zhi));
    register32 u_zlo (.i_clk(Clock), .i_rst_n(Clear), .i_en(Zin),   .i_d(w_c[31:0]),   .o_q(w_zlo));

    // IR, R4 and ZHigh have no reader inside this block yet.
    assign w_unused = ^{w_ir, w_r4, w_zhi};

    assign BusMuxOut = w_bus;
    assign Address   = w_mar;

`ifdef DATAPATH_ONEHOT_CHECK_EN
    always @(posedge Clock) begin
        if (Clear && ($countones({MDRout, Zlowout, PCout, R3out, R7out}) > 1)) begin
            $error("datapath: multiple bus sources asserted");
        end
    end
`endif

endmodule : datapath

// File: tb/tb_datapath.sv
// Table-driven bench for datapath: each vector drives one control step and
// names one observation; expectations flow through a scoreboard queue.
module tb_datapath;

    localparam logic [16:0] C_PCOUT = 17'h00001, C_ZLOUT = 17'h00002, C_MDROUT = 17'h00004,
                            C_R3OUT = 17'h00008, C_R7OUT = 17'h00010, C_MARIN  = 17'h00020,
                            C_ZIN   = 17'h00040, C_PCIN  = 17'h00080, C_MDRIN  = 17'h00100,
                            C_IRIN  = 17'h00200, C_YIN   = 17'h00400, C_INCPC  = 17'h00800,
                            C_READ  = 17'h01000, C_AND   = 17'h02000, C_R3IN   = 17'h04000,
                            C_R4IN  = 17'h08000, C_R7IN  = 17'h10000;

    typedef enum {CK_NONE, CK_BUS, CK_ADDR, CK_IR, CK_Y, CK_ZHI, CK_R4} chk_e;

    typedef struct {
        string       name;
        logic [16:0] ctrl;
        logic [31:0] mdat;
        chk_e        kind;
        logic [31:0] exp;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [16:0] ctrl  = '0;
    logic [31:0] Mdatain = '0;
    logic [31:0] BusMuxOut, Address;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    datapath dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(ctrl[0]), .Zlowout(ctrl[1]), .MDRout(ctrl[2]), .R3out(ctrl[3]), .R7out(ctrl[4]),
        .MARin(ctrl[5]), .Zin(ctrl[6]), .PCin(ctrl[7]), .MDRin(ctrl[8]), .IRin(ctrl[9]),
        .Yin(ctrl[10]), .IncPC(ctrl[11]), .Read(ctrl[12]), .AND(ctrl[13]),
        .R3in(ctrl[14]), .R4in(ctrl[15]), .R7in(ctrl[16]),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut), .Address(Address)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input chk_e kind);
        case (kind)
            CK_BUS:  return BusMuxOut;
            CK_ADDR: return Address;
            CK_IR:   return dut.u_ir.o_q;
            CK_Y:    return dut.u_y.o_q;
            CK_ZHI:  return dut.u_zhi.o_q;
            CK_R4:   return dut.u_r4.o_q;
            default: return '0;
        endcase
    endfunction

    function automatic void add(input string name, input logic [16:0] c, input logic [31:0] m,
                                input chk_e k, input logic [31:0] e);
        vec_t v;
        v.name = name; v.ctrl = c; v.mdat = m; v.kind = k; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Bus checks sample the combinational bus inside the driven cycle; all
    // other checks sample state one edge later.
    task automatic apply(input vec_t v);
        @(negedge Clock);
        ctrl    = v.ctrl;
        Mdatain = v.mdat;
        if (v.kind == CK_BUS) begin
            sb.push_back(v.exp);
            #1 check(v.name, observe(v.kind), sb.pop_front());
        end
        @(posedge Clock);
        #1;
        if (v.kind != CK_BUS && v.kind != CK_NONE) begin
            sb.push_back(v.exp);
            check(v.name, observe(v.kind), sb.pop_front());
        end
    endtask

    initial begin
        // Register preload
        add("pre_mdr_22",   C_READ | C_MDRIN,  32'h22, CK_NONE, 0);
        add("pre_r3",       C_MDROUT | C_R3IN, 32'h0,  CK_BUS,  32'h22);
        add("pre_mdr_24",   C_READ | C_MDRIN,  32'h24, CK_NONE, 0);
        add("pre_r7",       C_MDROUT | C_R7IN, 32'h0,  CK_BUS,  32'h24);
        add("pre_mdr_28",   C_READ | C_MDRIN,  32'h28, CK_NONE, 0);
        add("pre_r4",       C_MDROUT | C_R4IN, 32'h0,  CK_BUS,  32'h28);
        add("r4_is_28",     '0,                32'h0,  CK_R4,   32'h28);
        add("r3_on_bus",    C_R3OUT,           32'h0,  CK_BUS,  32'h22);
        add("r7_on_bus",    C_R7OUT,           32'h0,  CK_BUS,  32'h24);
        add("bus_idle",     '0,                32'h0,  CK_BUS,  32'h0);
        // Fetch
        add("t0_bus_pc",    C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 32'h0, CK_BUS, 32'h0);
        add("t1_bus_z",     C_ZLOUT | C_PCIN | C_READ | C_MDRIN, 32'h2A2B8000, CK_BUS, 32'h1);
        add("t2_bus_mdr",   C_MDROUT | C_IRIN, 32'h0,  CK_BUS,  32'h2A2B8000);
        add("ir_fetched",   '0,                32'h0,  CK_IR,   32'h2A2B8000);
        add("mar_fetched",  '0,                32'h0,  CK_ADDR, 32'h0);
        add("pc_after_t1",  C_PCOUT,           32'h0,  CK_BUS,  32'h1);
        // AND execute
        add("t3_bus_r3",    C_R3OUT | C_YIN,   32'h0,  CK_BUS,  32'h22);
        add("t4_bus_r7",    C_R7OUT | C_AND | C_ZIN, 32'h0, CK_BUS, 32'h24);
        add("t5_bus_zlo",   C_ZLOUT | C_R4IN,  32'h0,  CK_BUS,  32'h20);
        add("r4_and",       '0,                32'h0,  CK_R4,   32'h20);
        add("y_is_r3",      '0,                32'h0,  CK_Y,    32'h22);
        add("zhigh_zero",   '0,                32'h0,  CK_ZHI,  32'h0);
        // IncPC wrap through MDR-loaded PC
        add("wrap_mdr",     C_READ | C_MDRIN,  32'hFFFFFFFF, CK_NONE, 0);
        add("wrap_pc_load", C_MDROUT | C_PCIN, 32'h0,  CK_BUS,  32'hFFFFFFFF);
        add("wrap_t0",      C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 32'h0, CK_BUS, 32'hFFFFFFFF);
        add("wrap_t1_zlo",  C_ZLOUT | C_PCIN | C_READ | C_MDRIN, 32'h9, CK_BUS, 32'h0);
        add("wrap_mar",     '0,                32'h0,  CK_ADDR, 32'hFFFFFFFF);
        add("wrap_pc_zero", C_PCOUT,           32'h0,  CK_BUS,  32'h0);
        // AND wins over IncPC
        add("and_over_inc", C_R7OUT | C_AND | C_INCPC | C_ZIN, 32'h0, CK_BUS, 32'h24);
        add("and_over_res", C_ZLOUT,           32'h0,  CK_BUS,  32'h20);
        // Bus priority with several sources
        add("r3_load_9",    C_MDROUT | C_R3IN, 32'h0,  CK_BUS,  32'h9);
        add("mdr_5",        C_READ | C_MDRIN,  32'h5,  CK_NONE, 0);
        add("prio_mdr_r3",  C_MDROUT | C_R3OUT, 32'h0, CK_BUS,  32'h5);
        add("prio_zlo",     C_ZLOUT | C_PCOUT | C_R3OUT | C_R7OUT, 32'h0, CK_BUS, 32'h20);
        add("prio_pc",      C_PCOUT | C_R3OUT | C_R7OUT, 32'h0, CK_BUS, 32'h0);
        add("prio_r3",      C_R3OUT | C_R7OUT, 32'h0,  CK_BUS,  32'h9);
        // Set PC and MAR to a nonzero value ahead of the mid-sequence reset
        add("mdr_77",       C_READ | C_MDRIN,  32'h77, CK_NONE, 0);
        add("pc_mar_77",    C_MDROUT | C_PCIN | C_MARIN, 32'h0, CK_BUS, 32'h77);
        add("mar_77",       C_PCOUT,           32'h0,  CK_ADDR, 32'h77);

        // Reset state
        #12;
        check("reset_bus",  BusMuxOut, 32'h0);
        check("reset_addr", Address,    32'h0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        check("idle_addr", Address,   32'h0);
        check("idle_bus",  BusMuxOut, 32'h0);
        @(negedge Clock);
        ctrl = C_PCOUT;
        #1 check("idle_pc", BusMuxOut, 32'h0);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted mid-cycle overrides a pending MDR load
        @(negedge Clock);
        ctrl    = C_READ | C_MDRIN | C_PCIN | C_MDROUT;
        Mdatain = 32'hABCD;
        #2 Clear = 1'b0;
        #1;
        check("rst_async_addr", Address, 32'h0);
        @(posedge Clock);
        #1;
        check("rst_mdr_bus", BusMuxOut, 32'h0);
        @(negedge Clock);
        ctrl  = C_PCOUT;
        Clear = 1'b1;
        #1 check("rst_pc_bus", BusMuxOut, 32'h0);
        ctrl = C_MDROUT;
        #1 check("rst_mdr_after", BusMuxOut, 32'h0);
        ctrl = '0;

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_datapath
